// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared defaults and helpers for the multi-channel servo PWM.
// Slew limiting is enabled by defining SERVO_PWM_SLEW_EN.
`timescale 1ns/1ps
package servo_pwm_pkg;

  localparam int CNT_W_DEF     = 20;
  localparam int PERIOD_DEF    = 1_000_000;
  localparam int SLEW_STEP_DEF = 500;

  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// servo_pwm_ch: one PWM channel with target/active duty and enable latch.
// SERVO_PWM_SLEW_EN ramps active toward target by at most SLEW_STEP.
`timescale 1ns/1ps
module servo_pwm_ch #(
  parameter int CNT_W = 20
`ifdef SERVO_PWM_SLEW_EN
  , parameter int SLEW_STEP = 500
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bnd,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_duty,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_tgt;
  logic [CNT_W-1:0] r_act;
  logic             r_en;
  logic             r_pwm;
  logic [CNT_W-1:0] w_nxt;

`ifdef SERVO_PWM_SLEW_EN
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(SLEW_STEP);

  logic [CNT_W:0] w_t;
  logic [CNT_W:0] w_a;
  logic [CNT_W:0] w_d;
  logic [CNT_W:0] w_s;
  logic           w_up;

  // One extra bit keeps the difference and the sum free of wrap.
  always_comb begin
    w_t   = {1'b0, r_tgt};
    w_a   = {1'b0, r_act};
    w_up  = w_t > w_a;
    w_d   = w_up ? (w_t - w_a) : (w_a - w_t);
    w_s   = (w_d > STEP) ? STEP : w_d;
    w_nxt = w_up ? CNT_W'(w_a + w_s)
                 : CNT_W'(w_a - w_s);
  end
`else
  assign w_nxt = r_tgt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt <= '0;
      r_act <= '0;
      r_en  <= 1'b0;
      r_pwm <= 1'b0;
    end else begin
      if (i_we)
        r_tgt <= i_duty;
      if (i_bnd) begin
        r_act <= w_nxt;
        r_en  <= i_en;
      end
      r_pwm <= r_en && (i_cnt < r_act);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: CH servo PWM outputs sharing one period counter.
// Define SERVO_PWM_SLEW_EN to slew-limit duty changes per period.
`timescale 1ns/1ps
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int CH        = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int SLEW_STEP = SLEW_STEP_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ch_idx_w(CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]        wr_duty,
  input  logic [CH-1:0]           ch_en,
  output logic [CH-1:0]           pwm_wave,
  output logic                    period_start
);

  localparam int IW = ch_idx_w(CH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  if (CH < 1 || CH > 16 || PERIOD < 2 || SLEW_STEP < 0 ||
      longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("servo_pwm_multi: parameter out of range");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_rdy;
  logic             r_pstart;
  logic             w_bnd;
  logic             w_acc;
  logic [CH-1:0]    w_we;

  assign w_bnd    = (r_cnt == LAST);
  assign wr_ready = r_rdy && !w_bnd;
  assign w_acc    = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rdy    <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_cnt    <= w_bnd ? '0 : r_cnt + CNT_W'(1);
      r_rdy    <= 1'b1;
      r_pstart <= (r_cnt == '0);
    end
  end

  assign period_start = r_pstart;

  // Out-of-range channel indices match no channel, so the write is dropped.
  always_comb begin
    w_we = '0;
    for (int i = 0; i < CH; i++)
      w_we[i] = w_acc && (wr_ch == IW'(i));
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    servo_pwm_ch #(
      .CNT_W(CNT_W)
`ifdef SERVO_PWM_SLEW_EN
      , .SLEW_STEP(SLEW_STEP)
`endif
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_bnd (w_bnd),
      .i_we  (w_we[gi]),
      .i_duty(wr_duty),
      .i_en  (ch_en[gi]),
      .i_cnt (r_cnt),
      .o_pwm (pwm_wave[gi])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed + random checks against a period-level model.
// Expected slew behaviour follows SERVO_PWM_SLEW_EN when defined.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

  localparam int CH   = 4;
  localparam int CW   = 8;
  localparam int PER  = 100;
  localparam int STEP = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_ch = '0;
  logic [CW-1:0] wr_duty = '0;
  logic [CH-1:0] ch_en = '0;
  logic [CH-1:0] pwm_wave;
  logic          period_start;

  int total = 0;
  int bad = 0;

  // ph: position within the period as seen on the outputs; -1 = no edge yet
  int ph = -1;
  int tgt[CH];
  int act[CH];
  int shown_act[CH];
  bit en_nxt[CH];
  bit shown_en[CH];

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CH(CH), .CNT_W(CW), .PERIOD(PER), .SLEW_STEP(STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .ch_en       (ch_en),
    .pwm_wave    (pwm_wave),
    .period_start(period_start)
  );

  function automatic int toward(int a, int t);
`ifdef SERVO_PWM_SLEW_EN
    if (t > a) return a + (((t - a) < STEP) ? (t - a) : STEP);
    if (a > t) return a - (((a - t) < STEP) ? (a - t) : STEP);
    return a;
`else
    return t;
`endif
  endfunction

  function automatic bit exp_rdy();
    return rst_n && (ph >= 0) && (ph != PER - 2);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    ph = -1;
    for (int i = 0; i < CH; i++) begin
      tgt[i] = 0; act[i] = 0; shown_act[i] = 0;
      en_nxt[i] = 0; shown_en[i] = 0;
    end
  endtask

  task automatic tick();
    bit v, r, bnd;
    int c, d;
    logic [CH-1:0] e;
    v = wr_valid; r = exp_rdy(); c = wr_ch; d = wr_duty;
    e = ch_en; bnd = (ph == PER - 2);
    chk("wr_ready", wr_ready, r);
    @(posedge clk); #1;
    if (v && r && c < CH) tgt[c] = d;
    if (bnd)
      for (int i = 0; i < CH; i++) begin
        act[i] = toward(act[i], tgt[i]);
        en_nxt[i] = e[i];
      end
    ph = (ph + 1) % PER;
    if (ph == 0)
      for (int i = 0; i < CH; i++) begin
        shown_act[i] = act[i];
        shown_en[i] = en_nxt[i];
      end
    chk("period_start", period_start, ph == 0);
    for (int i = 0; i < CH; i++)
      chk($sformatf("pwm%0d", i), pwm_wave[i],
          shown_en[i] && (ph < shown_act[i]));
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic wait_ph(int p);
    int k;
    k = 0;
    while (ph != p && k < 2 * PER) begin tick(); k++; end
    if (ph != p) begin
      bad++;
      $error("FAIL wait_ph got=%0d want=%0d", ph, p);
    end
  endtask

  task automatic wr(int c, int d);
    bit done;
    done = 0;
    wr_valid = 1'b1; wr_ch = 2'(c); wr_duty = CW'(d);
    for (int k = 0; k < 4 && !done; k++) begin
      done = exp_rdy();
      tick();
    end
    if (!done) begin
      bad++;
      $error("FAIL wr_handshake got=0 want=1");
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("rst_pwm", pwm_wave, 0);
    chk("rst_pstart", period_start, 0);
    chk("rst_ready", wr_ready, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rel_ready", wr_ready, 0);
  endtask

  int hi;
  int exp_hi[5];

  initial begin
`ifdef SERVO_PWM_SLEW_EN
    exp_hi = '{10, 20, 30, 35, 35};
`else
    exp_hi = '{35, 35, 35, 35, 35};
`endif
    #1;
    do_reset();
    ch_en = 4'hF;

    // ch0 at 30, others idle
    wr(0, 30);
    run(3 * PER);

    // clamps: zero, exactly PERIOD, above PERIOD
    wr(1, 0); wr(2, 100); wr(3, 255);
    run(3 * PER);

    // write held through the boundary cycle
    wait_ph(PER - 2);
    wr(1, 50);
    run(2 * PER + 10);

    // enable dropped mid-pulse
    wait_ph(10);
    ch_en[0] = 1'b0;
    run(2 * PER);

    // slew ramp of ch0 from 0 to 35
    ch_en = 4'hF;
    wr(0, 0);
    run(5 * PER);
    wait_ph(50);
    wr(0, 35);
    wait_ph(0);
    for (int p = 0; p < 5; p++) begin
      hi = 0;
      repeat (PER) begin
        hi += int'(pwm_wave[0]);
        tick();
      end
      chk($sformatf("hi_time%0d", p), hi, exp_hi[p]);
    end

    // random writes and enable changes
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) ch_en = CH'($urandom);
      wr(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)));
      run(int'($urandom_range(0, 60)));
    end

    // reset asserted while ch2 is mid-pulse
    ch_en = 4'hF;
    wr(2, 100);
    run(2 * PER);
    wait_ph(5);
    chk("pre_rst_ch2", pwm_wave[2], 1);
    do_reset();
    run(2 * PER + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
